rr_arbiter_16: RTL and testbench

Round-robin arbiter that shares one resource among 16 requesters and drives a one-hot 16-bit grant through a 4-to-16 decode of the winning index. It sits in front of any resource whose select lines are fed by the team's 4-to-16 decoder: requesters raise `req`, the arbiter picks one fairly, holds the grant until release or timeout, then rotates priority.

---
 rtl/rr_arbiter_16_pkg.sv | 24 ++
 rtl/rr_arbiter_16_if.sv | 23 ++
 rtl/four_to_sixteen_decoder.sv | 14 +
 rtl/rr_arbiter_16.sv | 103 ++++++++++
 tb/tb_rr_arbiter_16.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_16_pkg.sv
// rr_arbiter_16 shared types and constants.
// State encoding, sizes and the priority-encoder helper.
package rr_arbiter_16_pkg;

  localparam int NUM_REQ = 16;
  localparam int ID_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Lowest set bit wins; zero when nothing is set.
  function automatic logic [ID_W-1:0] first_set(
    input logic [NUM_REQ-1:0] v
  );
    first_set = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) first_set = ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between requesters and rr_arbiter_16.
// The master side drives requests, the slave side drives grants.
interface rr_arbiter_16_if;
  import rr_arbiter_16_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  logic               timeout;

  modport master (
    output req, done,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_id, grant_valid, timeout
  );

endinterface

// File: rtl/four_to_sixteen_decoder.sv
// 4-to-16 one-hot decoder with enable.
// Output is all-zero while en is low.
module four_to_sixteen_decoder (
  input  logic [3:0]  a,
  input  logic        en,
  output logic [15:0] y
);

  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with hold timeout and one-cycle gap.
// Grant is decoded from the registered owner index.
module rr_arbiter_16 #(
  parameter int MAX_HOLD = 255,
  parameter int HOLD_W   = 8
) (
  input logic        clk,
  input logic        rst_n,
  rr_arbiter_16_if.slave bus
);
  import rr_arbiter_16_pkg::*;

  localparam logic [HOLD_W-1:0] LIMIT =
    HOLD_W'(MAX_HOLD - 1);

  state_t             state, state_d;
  logic [ID_W-1:0]    ptr, ptr_d;
  logic [ID_W-1:0]    grant_id, id_d;
  logic [ID_W-1:0]    win;
  logic [HOLD_W-1:0]  hold_cnt, hold_d;
  logic               grant_valid, vld_d;
  logic               timeout, to_d;
  logic [NUM_REQ-1:0] rot;
  logic               hit, rel;

  // Rotate so ptr lands on bit 0, then pick the lowest set bit.
  always_comb begin
    rot = NUM_REQ'({bus.req, bus.req} >> ptr);
    win = ptr + first_set(rot);
  end

  always_comb begin
    hit = (MAX_HOLD != 0) && (hold_cnt == LIMIT);
    rel = bus.done || !bus.req[grant_id] || hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      hold_cnt    <= hold_d;
      grant_id    <= id_d;
      grant_valid <= vld_d;
      timeout     <= to_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (|bus.req) state_d = GRANT;
      GRANT:   if (rel) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d  = ptr;
    hold_d = hold_cnt;
    id_d   = grant_id;
    vld_d  = grant_valid;
    to_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          id_d   = win;
          vld_d  = 1'b1;
          hold_d = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = grant_id + 4'd1;
          id_d  = '0;
          vld_d = 1'b0;
          to_d  = hit;
        end else if (hold_cnt != '1) begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  four_to_sixteen_decoder u_dec (
    .a  (grant_id),
    .en (grant_valid),
    .y  (bus.grant)
  );

  assign bus.grant_id    = grant_id;
  assign bus.grant_valid = grant_valid;
  assign bus.timeout     = timeout;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16 with a hold limit of 4.
// Scenario tasks run in sequence and check outputs inline.
module tb_rr_arbiter_16;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  rr_arbiter_16_if bus ();

  rr_arbiter_16 #(
    .MAX_HOLD (4),
    .HOLD_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.done = 1'b0;
    #12;
    checks++;
    if (bus.grant !== 16'h0 || bus.grant_id !== 4'd0 ||
        bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset got g=%h id=%0d v=%b t=%b want zeros",
        bus.grant, bus.grant_id, bus.grant_valid, bus.timeout);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.req = 16'h0010;
    tick();
    checks++;
    if (bus.grant !== 16'h0010 || bus.grant_id !== 4'd4 ||
        bus.grant_valid !== 1'b1) begin
      fails++;
      $display("FAIL single_grant got g=%h id=%0d v=%b want 0010/4/1",
        bus.grant, bus.grant_id, bus.grant_valid);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.grant !== 16'h0 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL single_release got g=%h t=%b want 0000/0",
        bus.grant, bus.timeout);
    end
    tick();
    checks++;
    if (bus.grant !== 16'h0) begin
      fails++;
      $display("FAIL single_gap got %h want 0000", bus.grant);
    end
    tick();
    checks++;
    if (bus.grant !== 16'h0010 || bus.grant_id !== 4'd4) begin
      fails++;
      $display("FAIL single_regrant got g=%h id=%0d want 0010/4",
        bus.grant, bus.grant_id);
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_rotation();
    int exp_id [4] = '{15, 0, 15, 0};
    logic [15:0] e;
    bus.req = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = 16'h0001 << exp_id[k];
      checks++;
      if (bus.grant_id !== 4'(exp_id[k]) || bus.grant !== e) begin
        fails++;
        $display("FAIL rot_%0d got id=%0d g=%h want id=%0d g=%h",
          k, bus.grant_id, bus.grant, exp_id[k], e);
      end
      tick();
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      checks++;
      if (bus.grant !== 16'h0 || bus.timeout !== 1'b0) begin
        fails++;
        $display("FAIL rot_rel_%0d got g=%h t=%b want 0000/0",
          k, bus.grant, bus.timeout);
      end
      if (k == 3) bus.req = '0;
      tick();
    end
  endtask

  task automatic test_wrap();
    bus.req = 16'h4000;
    tick();
    checks++;
    if (bus.grant_id !== 4'd14) begin
      fails++;
      $display("FAIL wrap_14 got %0d want 14", bus.grant_id);
    end
    bus.req = 16'h0003;
    tick();
    tick();
    tick();
    checks++;
    if (bus.grant !== 16'h0001 || bus.grant_id !== 4'd0) begin
      fails++;
      $display("FAIL wrap_0 got g=%h id=%0d want 0001/0",
        bus.grant, bus.grant_id);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.grant !== 16'h0002 || bus.grant_id !== 4'd1) begin
      fails++;
      $display("FAIL wrap_1 got g=%h id=%0d want 0002/1",
        bus.grant, bus.grant_id);
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    bus.req = 16'h0100;
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.grant !== 16'h0100 || bus.timeout !== 1'b0) begin
        fails++;
        $display("FAIL to_hold_%0d got g=%h t=%b want 0100/0",
          c, bus.grant, bus.timeout);
      end
      if (c < 3) tick();
    end
    tick();
    checks++;
    if (bus.grant !== 16'h0 || bus.timeout !== 1'b1 ||
        bus.grant_valid !== 1'b0) begin
      fails++;
      $display("FAIL to_revoke got g=%h t=%b v=%b want 0000/1/0",
        bus.grant, bus.timeout, bus.grant_valid);
    end
    tick();
    checks++;
    if (bus.grant !== 16'h0 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL to_gap got g=%h t=%b want 0000/0",
        bus.grant, bus.timeout);
    end
    tick();
    checks++;
    if (bus.grant !== 16'h0100 || bus.grant_id !== 4'd8) begin
      fails++;
      $display("FAIL to_regrant got g=%h id=%0d want 0100/8",
        bus.grant, bus.grant_id);
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_withdraw();
    bus.req = 16'h0008;
    tick();
    checks++;
    if (bus.grant_id !== 4'd3) begin
      fails++;
      $display("FAIL wd_grant got %0d want 3", bus.grant_id);
    end
    bus.req = 16'h0001;
    tick();
    checks++;
    if (bus.grant !== 16'h0 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL wd_release got g=%h t=%b want 0000/0",
        bus.grant, bus.timeout);
    end
    bus.req = '0;
    tick();
    bus.req = 16'h0008;
    tick();
    tick();
    tick();
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.grant !== 16'h0 || bus.timeout !== 1'b1) begin
      fails++;
      $display("FAIL simul_release got g=%h t=%b want 0000/1",
        bus.grant, bus.timeout);
    end
    bus.req = '0;
    tick();
    checks++;
    if (bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL simul_pulse got t=%b want 0", bus.timeout);
    end
  endtask

  task automatic test_async_reset();
    bus.req = 16'h0040;
    tick();
    checks++;
    if (bus.grant !== 16'h0040) begin
      fails++;
      $display("FAIL ar_grant got %h want 0040", bus.grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.grant !== 16'h0 || bus.grant_id !== 4'd0 ||
        bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL ar_clear got g=%h id=%0d v=%b t=%b want zeros",
        bus.grant, bus.grant_id, bus.grant_valid, bus.timeout);
    end
    #2;
    rst_n = 1'b1;
    bus.req = 16'hFFFF;
    tick();
    checks++;
    if (bus.grant !== 16'h0001 || bus.grant_id !== 4'd0) begin
      fails++;
      $display("FAIL ar_restart got g=%h id=%0d want 0001/0",
        bus.grant, bus.grant_id);
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_withdraw();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
